bilinear_job_ctrl: RTL and testbench

Job sequencer that sits between the host register block and bilinear_top's CSR port. It accepts one downscale job at a time through a valid/ready handshake and validates the dimensions. It computes the output size and the Q8.8 inverse scale with an iterative divider, programs the core, polls for completion with a timeout, then reads back the perf counters. It replaces ad-hoc CSR writes in the top with a single owner of the CSR bus.

---
 rtl/bilinear_job_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_bilinear_job_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bilinear_job_ctrl.sv
// Job sequencer owning bilinear_top's CSR bus: validates a downscale job, derives the output
// size and Q8.8 inverse scale, programs and polls the core, then collects its perf counters.
module bilinear_job_ctrl #(
  parameter int IMG_MAX_W   = 32,
  parameter int IMG_MAX_H   = 32,
  parameter int POLL_GAP    = 4,
  parameter int TIMEOUT_CYC = 1048576
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        job_valid,
  output logic        job_ready,
  input  logic [15:0] job_img_w,
  input  logic [15:0] job_img_h,
  input  logic [15:0] job_scale,
  input  logic        abort,
  output logic        csr_we,
  output logic [3:0]  csr_addr,
  output logic [31:0] csr_wdata,
  input  logic [31:0] csr_rdata,
  output logic        busy,
  output logic        done,
  output logic        err_cfg,
  output logic        err_timeout,
  output logic [15:0] res_out_w,
  output logic [15:0] res_out_h,
  output logic [15:0] res_inv_scale,
  output logic [31:0] res_perf_cyc,
  output logic [31:0] res_perf_pix
);
  localparam logic [3:0]  A_CTRL   = 4'd0;
  localparam logic [3:0]  A_STATUS = 4'd1;
  localparam logic [3:0]  A_SCALE  = 4'd2;
  localparam logic [3:0]  A_IN     = 4'd3;
  localparam logic [3:0]  A_OUT    = 4'd4;
  localparam logic [3:0]  A_PCYC   = 4'd5;
  localparam logic [3:0]  A_PPIX   = 4'd6;
  localparam logic [15:0] MAX_W    = 16'(IMG_MAX_W);
  localparam logic [15:0] MAX_H    = 16'(IMG_MAX_H);
  localparam logic [15:0] GAP_LAST = 16'(POLL_GAP - 1);
  localparam logic [31:0] TO_LIM   = 32'(TIMEOUT_CYC);

  typedef enum logic [3:0] {
    S_IDLE, S_CHECK, S_DIV, S_CFG_SCALE, S_CFG_IN, S_CFG_OUT, S_CFG_CTRL,
    S_POLL_WAIT, S_POLL_ADDR, S_POLL_CHK, S_RD_CYC, S_RD_PIX, S_STOP, S_FIN
  } state_t;

  state_t      state, state_d;
  logic [15:0] w_q, h_q, scale_q, rem_q, quot_q, gap_cnt;
  logic [4:0]  div_cnt;
  logic [31:0] to_cnt;
  logic        rd_phase;

  logic        csr_we_d;
  logic [3:0]  csr_addr_d;
  logic [31:0] csr_wdata_d;
  logic        dims_bad, stop_req, div_last, div_ge;
  logic [16:0] rem_sh, quot_nx;
  logic [15:0] rem_nx, inv_div, ow_fit, oh_fit;

  // Scaled dimension clamped to [1, lim] and never larger than the input dimension.
  function automatic logic [15:0] fit_dim(input logic [15:0] dim, input logic [15:0] s,
                                          input logic [15:0] lim);
    logic [31:0] r;
    r = ({16'h0, dim} * {16'h0, s}) >> 8;
    if (r == 32'd0) r = 32'd1;
    if (r > {16'h0, lim}) r = {16'h0, lim};
    if (r > {16'h0, dim}) r = {16'h0, dim};
    return r[15:0];
  endfunction

  // Restoring divide of 65536 by scale: the only set dividend bit enters on the first step.
  always_comb begin
    dims_bad = (w_q == 16'd0) || (h_q == 16'd0) || (w_q > MAX_W) || (h_q > MAX_H);
    ow_fit   = fit_dim(w_q, scale_q, MAX_W);
    oh_fit   = fit_dim(h_q, scale_q, MAX_H);
    rem_sh   = {rem_q, (div_cnt == 5'd0)};
    div_ge   = rem_sh >= {1'b0, scale_q};
    rem_nx   = div_ge ? 16'(rem_sh - {1'b0, scale_q}) : rem_sh[15:0];
    quot_nx  = {quot_q, div_ge};
    inv_div  = quot_nx[16] ? 16'hFFFF : quot_nx[15:0];
    div_last = (div_cnt == 5'd16);
    stop_req = abort || (to_cnt >= TO_LIM);
  end

  // NOTE: every signal gets a default before the case, so no path can infer a latch.
  always_comb begin
    state_d     = state;
    csr_we_d    = 1'b0;
    csr_addr_d  = csr_addr;
    csr_wdata_d = csr_wdata;
    unique case (state)
      S_IDLE:      if (job_valid) state_d = S_CHECK;
      S_CHECK:     if (abort || dims_bad) state_d = S_FIN;
                   else if (scale_q == 16'd0) state_d = S_CFG_SCALE;
                   else state_d = S_DIV;
      S_DIV:       if (abort) state_d = S_FIN;
                   else if (div_last) state_d = S_CFG_SCALE;
      S_CFG_SCALE: state_d = stop_req ? S_STOP : S_CFG_IN;
      S_CFG_IN:    state_d = stop_req ? S_STOP : S_CFG_OUT;
      S_CFG_OUT:   state_d = stop_req ? S_STOP : S_CFG_CTRL;
      S_CFG_CTRL:  state_d = stop_req ? S_STOP : S_POLL_WAIT;
      S_POLL_WAIT: if (stop_req) state_d = S_STOP;
                   else if (gap_cnt == GAP_LAST) state_d = S_POLL_ADDR;
      S_POLL_ADDR: state_d = stop_req ? S_STOP : S_POLL_CHK;
      S_POLL_CHK:  if (stop_req) state_d = S_STOP;
                   else state_d = csr_rdata[1] ? S_RD_CYC : S_POLL_WAIT;
      S_RD_CYC:    if (rd_phase) state_d = S_RD_PIX;
      S_RD_PIX:    if (rd_phase) state_d = S_FIN;
      S_STOP:      state_d = S_FIN;
      S_FIN:       state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase

    // CSR outputs are registered, so they are decoded from the state being entered.
    unique case (state_d)
      S_CFG_SCALE: begin
        csr_we_d    = 1'b1;
        csr_addr_d  = A_SCALE;
        csr_wdata_d = {16'h0, (state == S_DIV) ? inv_div : 16'h0100};
      end
      S_CFG_IN:    begin csr_we_d = 1'b1; csr_addr_d = A_IN;   csr_wdata_d = {w_q, h_q}; end
      S_CFG_OUT:   begin csr_we_d = 1'b1; csr_addr_d = A_OUT;  csr_wdata_d = {res_out_w, res_out_h}; end
      S_CFG_CTRL:  begin csr_we_d = 1'b1; csr_addr_d = A_CTRL; csr_wdata_d = 32'h3; end
      S_STOP:      begin csr_we_d = 1'b1; csr_addr_d = A_CTRL; csr_wdata_d = 32'h0; end
      S_POLL_ADDR, S_IDLE: csr_addr_d = A_STATUS;
      S_RD_CYC:    csr_addr_d = A_PCYC;
      S_RD_PIX:    csr_addr_d = A_PPIX;
      default:     ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      job_ready     <= 1'b1;
      busy          <= 1'b0;
      done          <= 1'b0;
      csr_we        <= 1'b0;
      csr_addr      <= A_STATUS;
      csr_wdata     <= 32'h0;
      err_cfg       <= 1'b0;
      err_timeout   <= 1'b0;
      res_out_w     <= 16'h0;
      res_out_h     <= 16'h0;
      res_inv_scale <= 16'h0100;
      res_perf_cyc  <= 32'h0;
      res_perf_pix  <= 32'h0;
      w_q           <= 16'h0;
      h_q           <= 16'h0;
      scale_q       <= 16'h0;
      rem_q         <= 16'h0;
      quot_q        <= 16'h0;
      div_cnt       <= 5'd0;
      gap_cnt       <= 16'h0;
      to_cnt        <= 32'h0;
      rd_phase      <= 1'b0;
    end else begin
      state     <= state_d;
      csr_we    <= csr_we_d;
      csr_addr  <= csr_addr_d;
      csr_wdata <= csr_wdata_d;
      job_ready <= (state_d == S_IDLE);
      busy      <= (state_d != S_IDLE) && (state_d != S_FIN);
      done      <= (state_d == S_FIN);
      gap_cnt   <= (state == S_POLL_WAIT && state_d == S_POLL_WAIT) ? gap_cnt + 16'd1 : 16'd0;
      if (state inside {S_POLL_WAIT, S_POLL_ADDR, S_POLL_CHK}) to_cnt <= to_cnt + 32'd1;
      unique case (state)
        S_IDLE: if (job_valid) begin
          w_q         <= job_img_w;
          h_q         <= job_img_h;
          scale_q     <= job_scale;
          err_cfg     <= 1'b0;
          err_timeout <= 1'b0;
          to_cnt      <= 32'h0;
        end
        S_CHECK: begin
          if (abort) err_timeout <= 1'b1;
          else if (dims_bad) err_cfg <= 1'b1;
          else begin
            res_out_w <= ow_fit;
            res_out_h <= oh_fit;
            rem_q     <= 16'h0;
            quot_q    <= 16'h0;
            div_cnt   <= 5'd0;
            if (scale_q == 16'd0) res_inv_scale <= 16'h0100;
          end
        end
        S_DIV: begin
          rem_q   <= rem_nx;
          quot_q  <= quot_nx[15:0];
          div_cnt <= div_cnt + 5'd1;
          if (abort) err_timeout <= 1'b1;
          else if (div_last) res_inv_scale <= inv_div;
        end
        S_CFG_CTRL: to_cnt <= 32'h0;
        S_RD_CYC: begin
          rd_phase <= !rd_phase;
          if (rd_phase) res_perf_cyc <= csr_rdata;
        end
        S_RD_PIX: begin
          rd_phase <= !rd_phase;
          if (rd_phase) res_perf_pix <= csr_rdata;
        end
        S_STOP:  err_timeout <= 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_bilinear_job_ctrl.sv
// Randomized bench for bilinear_job_ctrl: a behavioural core answers the CSR bus and an
// arithmetic job model predicts every write, timing window and result register.
module tb_bilinear_job_ctrl;
  localparam int TO_CYC = 1000;
  localparam int GAP    = 4;
  localparam int MAXD   = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        job_valid, job_ready, abort;
  logic [15:0] job_img_w, job_img_h, job_scale;
  logic        csr_we;
  logic [3:0]  csr_addr;
  logic [31:0] csr_wdata, csr_rdata;
  logic        busy, done, err_cfg, err_timeout;
  logic [15:0] res_out_w, res_out_h, res_inv_scale;
  logic [31:0] res_perf_cyc, res_perf_pix;

  bilinear_job_ctrl #(.IMG_MAX_W(MAXD), .IMG_MAX_H(MAXD), .POLL_GAP(GAP), .TIMEOUT_CYC(TO_CYC)) dut (
    .clk(clk), .rst(rst), .job_valid(job_valid), .job_ready(job_ready),
    .job_img_w(job_img_w), .job_img_h(job_img_h), .job_scale(job_scale), .abort(abort),
    .csr_we(csr_we), .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
    .busy(busy), .done(done), .err_cfg(err_cfg), .err_timeout(err_timeout),
    .res_out_w(res_out_w), .res_out_h(res_out_h), .res_inv_scale(res_inv_scale),
    .res_perf_cyc(res_perf_cyc), .res_perf_pix(res_perf_pix)
  );

  always #5 clk = ~clk;

  // Behavioural core: STATUS.DONE rises a fixed latency after CTRL=3, perf counters are constants.
  logic        core_run, core_never;
  int          core_cnt;
  logic [31:0] core_pcyc, core_ppix;
  always_comb begin
    case (csr_addr)
      4'd1:    csr_rdata = {30'h0, core_run && !core_never && (core_cnt == 0), 1'b0};
      4'd5:    csr_rdata = core_pcyc;
      4'd6:    csr_rdata = core_ppix;
      default: csr_rdata = 32'h0;
    endcase
  end

  typedef struct packed {
    logic [3:0]  a;
    logic [31:0] d;
    logic [31:0] t;
  } wr_t;
  wr_t wq[$];

  int n_checks = 0;
  int n_errors = 0;
  int          exp_ow, exp_oh, exp_inv;
  logic [31:0] exp_pc, exp_pp;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int model_dim(input int d, input int s);
    int r;
    r = (d * s) >> 8;
    if (r < 1) r = 1;
    if (r > MAXD) r = MAXD;
    if (r > d) r = d;
    return r;
  endfunction

  function automatic int model_inv(input int s);
    if (s == 0) return 256;
    return (65536 / s > 65535) ? 65535 : 65536 / s;
  endfunction

  task automatic model_reset();
    exp_ow = 0; exp_oh = 0; exp_inv = 256; exp_pc = 0; exp_pp = 0;
  endtask

  // lat<0: core never finishes. abort_abs: abort at that cycle after accept (CHECK is cycle 0).
  // abort_rel: abort that many cycles after the CTRL=3 write. poke: re-request while busy.
  task automatic run_job(input int w, input int h, input int s, input int lat,
                         input int abort_abs, input int abort_rel, input bit poke);
    int t, ctrl_t, done_t, t0, ok;
    bit bad, stopped;
    logic [3:0]  ea[4];
    logic [31:0] ed[4];
    wq.delete();
    ok = 0;
    for (int i = 0; i < 50 && ok == 0; i++) begin
      if (job_ready) ok = 1;
      else @(negedge clk);
    end
    check("ready_before_job", ok, 1);
    if (ok == 0) return;
    core_run = 0; core_never = (lat < 0); core_cnt = 0;
    core_pcyc = $urandom; core_ppix = $urandom;
    job_valid = 1; job_img_w = 16'(w); job_img_h = 16'(h); job_scale = 16'(s);
    @(negedge clk);
    job_valid = 0;
    check("accept_busy", busy, 1);
    check("accept_ready", job_ready, 0);
    ctrl_t = -1; done_t = -1;
    for (t = 0; t < 2000 && done_t < 0; t++) begin
      if (core_run && core_cnt > 0) core_cnt--;
      if (csr_we) begin
        wq.push_back({csr_addr, csr_wdata, 32'(t)});
        if (csr_addr == 4'd0 && csr_wdata == 32'h3) begin
          ctrl_t = t; core_run = 1; core_cnt = lat;
        end
      end
      if (done) done_t = t;
      else begin
        abort = (t == abort_abs) || (ctrl_t >= 0 && abort_rel >= 0 && t == ctrl_t + abort_rel);
        if (poke && t == 3) begin
          job_valid = 1; job_img_w = 16'd5; job_img_h = 16'd5; job_scale = 16'h0100;
          check("ready_while_busy", job_ready, 0);
        end
        if (poke && t == 6) job_valid = 0;
        @(negedge clk);
      end
    end
    abort = 0; job_valid = 0;
    check("done_seen", (done_t >= 0) ? 1 : 0, 1);
    if (done_t < 0) return;

    bad = (w == 0) || (h == 0) || (w > MAXD) || (h > MAXD);
    if (!bad && abort_abs >= 0) begin
      check("early_abort_nwr", wq.size(), 0);
      check("early_abort_done_t", done_t, abort_abs + 1);
      check("early_abort_err_to", err_timeout, 1);
      check("early_abort_err_cfg", err_cfg, 0);
      if (abort_abs >= 1) begin exp_ow = model_dim(w, s); exp_oh = model_dim(h, s); end
    end else if (bad) begin
      check("bad_nwr", wq.size(), 0);
      check("bad_done_t", done_t, 1);
      check("bad_err_cfg", err_cfg, 1);
      check("bad_err_to", err_timeout, 0);
    end else begin
      exp_ow = model_dim(w, s); exp_oh = model_dim(h, s); exp_inv = model_inv(s);
      ea[0] = 4'd2; ea[1] = 4'd3; ea[2] = 4'd4; ea[3] = 4'd0;
      ed[0] = 32'(exp_inv);
      ed[1] = (32'(w) << 16) | 32'(h);
      ed[2] = (32'(exp_ow) << 16) | 32'(exp_oh);
      ed[3] = 32'h3;
      t0 = (s == 0) ? 1 : 18;
      stopped = (lat < 0) || (abort_rel >= 0);
      check("nwr", wq.size(), stopped ? 5 : 4);
      for (int i = 0; i < 4; i++) begin
        if (i < wq.size()) begin
          check($sformatf("wr%0d_addr", i), wq[i].a, ea[i]);
          check($sformatf("wr%0d_data", i), wq[i].d, ed[i]);
          check($sformatf("wr%0d_cycle", i), wq[i].t, t0 + i);
        end
      end
      if (stopped && wq.size() == 5) begin
        check("stop_addr", wq[4].a, 0);
        check("stop_data", wq[4].d, 0);
        if (abort_rel >= 0) check("stop_after_abort", wq[4].t, ctrl_t + abort_rel + 1);
        else check("stop_near_timeout",
                   (int'(wq[4].t) - ctrl_t >= TO_CYC && int'(wq[4].t) - ctrl_t <= TO_CYC + 4) ? 1 : 0, 1);
        check("stop_done_t", done_t, int'(wq[4].t) + 1);
        check("stop_err_to", err_timeout, 1);
        check("stop_err_cfg", err_cfg, 0);
      end else if (!stopped) begin
        check("done_window", (done_t >= ctrl_t + lat + 5 && done_t <= ctrl_t + lat + GAP + 8) ? 1 : 0, 1);
        check("ok_err_cfg", err_cfg, 0);
        check("ok_err_to", err_timeout, 0);
        exp_pc = core_pcyc; exp_pp = core_ppix;
      end
    end
    check("res_out_w", res_out_w, exp_ow);
    check("res_out_h", res_out_h, exp_oh);
    check("res_inv", res_inv_scale, exp_inv);
    check("res_perf_cyc", res_perf_cyc, exp_pc);
    check("res_perf_pix", res_perf_pix, exp_pp);
    check("busy_at_done", busy, 0);
    check("ready_at_done", job_ready, 0);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("ready_after_done", job_ready, 1);
  endtask

  initial begin
    rst = 1; job_valid = 0; abort = 0;
    job_img_w = 0; job_img_h = 0; job_scale = 0;
    core_run = 0; core_never = 0; core_cnt = 0; core_pcyc = 0; core_ppix = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_ready", job_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_we", csr_we, 0);
    check("rst_addr", csr_addr, 1);
    check("rst_wdata", csr_wdata, 0);
    check("rst_inv", res_inv_scale, 16'h0100);
    check("rst_errs", {err_cfg, err_timeout}, 0);
    check("rst_perf", res_perf_cyc | res_perf_pix, 0);
    rst = 0;
    @(negedge clk);

    run_job(32, 32, 16'h0080, 300, -1, -1, 0);
    run_job(32, 32, 16'h0180, 20, -1, -1, 0);
    run_job(20, 10, 16'h0001, 7, -1, -1, 0);
    run_job(16, 8, 0, 12, -1, -1, 0);
    run_job(0, 10, 16'h0100, 5, -1, -1, 0);
    run_job(33, 10, 16'h0100, 5, -1, -1, 0);
    run_job(10, 33, 16'h0100, 5, -1, -1, 0);
    run_job(8, 8, 16'h0100, -1, -1, -1, 0);
    run_job(16, 16, 16'h00C0, -1, -1, 2, 1);
    run_job(10, 10, 16'h0100, 5, 0, -1, 0);
    run_job(12, 9, 16'h0100, 5, 6, -1, 0);
    run_job(32, 1, 16'h0100, 3, -1, -1, 0);

    // Asynchronous reset while the divider is running.
    job_valid = 1; job_img_w = 16'd12; job_img_h = 16'd12; job_scale = 16'h0090;
    @(negedge clk);
    job_valid = 0;
    repeat (5) @(negedge clk);
    rst = 1;
    #1;
    check("midrst_ready", job_ready, 1);
    check("midrst_busy", busy, 0);
    check("midrst_addr", csr_addr, 1);
    check("midrst_inv", res_inv_scale, 16'h0100);
    check("midrst_out", {res_out_w, res_out_h}, 0);
    @(negedge clk);
    rst = 0;
    model_reset();
    @(negedge clk);
    run_job(24, 18, 16'h00A0, 15, -1, -1, 0);

    for (int i = 0; i < 25; i++) begin
      int w, h, s, lat;
      w = $urandom_range(0, 34);
      h = $urandom_range(0, 34);
      case ($urandom_range(0, 3))
        0:       s = 0;
        1:       s = $urandom_range(1, 255);
        2:       s = $urandom_range(256, 1023);
        default: s = $urandom_range(1, 65535);
      endcase
      lat = $urandom_range(1, 40);
      run_job(w, h, s, lat, -1, -1, 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
